// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
//   rx_state_e  : receive framer states
//   PARITY_*    : parity-select encodings (1 = odd, 0 = even)
//   calc_parity : parity bit a transmitter sends for a word; data is
//                 zero-extended to 9 bits, which leaves the XOR unchanged.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_e;

  localparam logic PARITY_ODD  = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;

  // Returns the bit that makes ^{pbit, data} equal to sel.
  function automatic logic calc_parity(input logic [8:0] data, input logic sel);
    return (^data) ^ sel;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
//   clk_i : sampling clock
//   rst_i : synchronous active-high reset, both flops load RST_VAL
//   d_i   : asynchronous input
//   q_o   : synchronised output (2 clock latency)
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: 16x (OVS) oversampled start/data/parity/stop
// recovery with a single-word holding register.
//   HCLK, HRESET          : clock, synchronous active-high reset
//   BAUDTICK              : OVS pulses per bit period
//   RXD                   : asynchronous serial input, idle high
//   PARITYEN, PARITYSEL   : parity enable / odd(1) even(0), latched per frame
//   RX_ACK                : consumer pops the held word
//   RX_DATA, RX_VALID     : held word and its valid flag
//   PARITY_ERR, FRAME_ERR : error flags of the held word
//   OVERRUN               : a frame was dropped because the word was not popped
//   RX_BUSY               : framer not idle
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for a 1->0 edge on the synchronised line
// START     | counting to mid start bit, rejects glitches
// DATA      | sampling DWIDTH data bits, LSB first
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit, completing the frame
// BRK_WAIT  | line held low after a bad stop bit, wait for idle
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int OVS    = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              BAUDTICK,
  input  logic              RXD,
  input  logic              PARITYEN,
  input  logic              PARITYSEL,
  input  logic              RX_ACK,
  output logic [DWIDTH-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              PARITY_ERR,
  output logic              FRAME_ERR,
  output logic              OVERRUN,
  output logic              RX_BUSY
);

  localparam int CW = $clog2(OVS);
  localparam int IW = $clog2(DWIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVS - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(DWIDTH - 1);

  logic rxd_s;

  rx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     bit_q, bit_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic              pen_q, pen_d;
  logic              psel_q, psel_d;
  logic              fperr_q, fperr_d;
  logic              rxd_prev_q;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              at_half, at_full;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync_rxd (
    .clk_i (HCLK),
    .rst_i (HRESET),
    .d_i   (RXD),
    .q_o   (rxd_s)
  );

  assign at_half = BAUDTICK && (cnt_q == CNT_HALF);
  assign at_full = BAUDTICK && (cnt_q == CNT_FULL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pen_d   = pen_q;
    psel_d  = psel_q;
    fperr_d = fperr_q;
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (RX_ACK && valid_q) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    if (BAUDTICK && (state_q != ST_IDLE) && (state_q != ST_BRK_WAIT)) begin
      cnt_d = (cnt_q == CNT_FULL) ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rxd_prev_q && !rxd_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (at_half) begin
          // Restart the count at mid start bit so every later wrap lands mid-bit.
          cnt_d = '0;
          if (!rxd_s) begin
            pen_d   = PARITYEN;
            psel_d  = PARITYSEL;
            fperr_d = 1'b0;
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (at_full) begin
          shift_d[bit_q] = rxd_s;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = pen_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (at_full) begin
          fperr_d = (rxd_s != calc_parity(9'(shift_q), psel_q));
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (at_full) begin
          // An ack in the completion cycle frees the holding register in time.
          if (!valid_q || RX_ACK) begin
            data_d  = shift_q;
            perr_d  = fperr_q;
            ferr_d  = !rxd_s;
            valid_d = 1'b1;
            ovr_d   = 1'b0;
          end else begin
            ovr_d = 1'b1;
          end
          state_d = rxd_s ? ST_IDLE : ST_BRK_WAIT;
        end
      end
      ST_BRK_WAIT: begin
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      pen_q      <= 1'b0;
      psel_q     <= 1'b0;
      fperr_q    <= 1'b0;
      rxd_prev_q <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      pen_q      <= pen_d;
      psel_q     <= psel_d;
      fperr_q    <= fperr_d;
      rxd_prev_q <= rxd_s;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign RX_DATA    = data_q;
  assign RX_VALID   = valid_q;
  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;
  assign OVERRUN    = ovr_q;
  assign RX_BUSY    = (state_q != ST_IDLE);

endmodule
